// File: rtl/lenet_pkg.sv
// Shared LeNet datapath definitions: pixel width, kernel geometry and the window byte order.
// The conv datapath expects this same byte order on its ifmap bus.
package lenet_pkg;

  localparam int PIX_W      = 8;
  localparam int K          = 3;
  localparam int FILTERSIZE = K * K;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  // Byte slot of window element (r, c); r=0 is the top row and c=0 is the left column.
  function automatic int win_idx(input int r, input int c);
    return K * r + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel delay: single-port RAM with a combinational read of the old contents.
// Write is one cycle and is gated by the caller's accept; the buffer has no backpressure of its own.
module line_buffer
  import lenet_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          din,
  output pix_t          dout
);

  pix_t mem [DEPTH];

  // A read and a write to the same column happen in one cycle; the read returns the previous row.
  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 window stream; the window is registered one cycle after its completing pixel.
// A held window (win_valid & !win_ready) drops pix_ready; consuming and accepting in one cycle adds no bubble.
module conv_window_gen
  import lenet_pkg::*;
#(
  parameter int filtersize = FILTERSIZE,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [8*filtersize-1:0]   win,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [$clog2(IMG_H)-1:0]  win_row,
  output logic [$clog2(IMG_W)-1:0]  win_col,
  output logic                      win_last
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  phase_t        phase, phase_nxt;
  logic          accept, col_wrap, frame_wrap, emit;
  pix_t          lb0_q, lb1_q;
  pix_t          w [K][K];

  assign pix_ready  = !rst && (!win_valid || win_ready);
  assign accept     = pix_valid && pix_ready;
  assign col_wrap   = (col_cnt == COL_LAST);
  assign frame_wrap = col_wrap && (row_cnt == ROW_LAST);

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col_cnt),
    .din  (pix_in),
    .dout (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col_cnt),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_cnt <= '0;
        row_cnt <= frame_wrap ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_FILL;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Columns 0 and 1 of a row would mix pixels from two image rows, so they never emit.
  always_comb begin
    phase_nxt = phase;
    emit      = 1'b0;
    case (phase)
      PH_FILL: begin
        if (accept && col_wrap && (row_cnt == RW'(1))) begin
          phase_nxt = PH_RUN;
        end
      end
      PH_RUN: begin
        emit = accept && (col_cnt >= CW'(2));
        if (accept && frame_wrap) begin
          phase_nxt = PH_FILL;
        end
      end
      default: phase_nxt = PH_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          w[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          w[r][c] <= w[r][c+1];
        end
      end
      w[0][K-1] <= lb1_q;
      w[1][K-1] <= lb0_q;
      w[2][K-1] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win_valid <= emit;
      if (emit) begin
        win_row  <= row_cnt - RW'(2);
        win_col  <= col_cnt - CW'(2);
        win_last <= frame_wrap;
      end
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win[PIX_W*win_idx(r, c) +: PIX_W] = w[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on an 8x8 image with pixel value (8*row+col) mod 256.
module tb_conv_window_gen;
  import lenet_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [71:0] win;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        win_last;

  conv_window_gen #(.filtersize(9), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    int          row;
    int          col;
    bit          last;
  } win_t;

  win_t exp_q[$];
  win_t got[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_row = 0;
  int   m_col = 0;
  bit   last_vld;

  function automatic logic [7:0] val(input int r, input int c);
    return 8'((8 * r + c) % 256);
  endfunction

  function automatic logic [71:0] p9(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic win_t gi(input int i);
    win_t z;
    z.w = '0; z.row = -1; z.col = -1; z.last = 1'b0;
    if (i >= 0 && i < got.size()) return got[i];
    return z;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Spec-level reference: the pixel at (m_row, m_col) completes a window when both are >= 2.
  task automatic model_accept();
    win_t e;
    if (m_row >= 2 && m_col >= 2) begin
      e.w = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[8*(3*i+j) +: 8] = val(m_row - 2 + i, m_col - 2 + j);
      e.row  = m_row - 2;
      e.col  = m_col - 2;
      e.last = (m_row == H - 1) && (m_col == W - 1);
      exp_q.push_back(e);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endtask

  task automatic cycle(input bit pv, input bit wr, output bit acc);
    @(negedge clk);
    pix_valid = pv;
    win_ready = wr;
    pix_in    = val(m_row, m_col);
    #1;
    last_vld = win_valid;
    acc = pv && pix_ready;
    if (acc) model_accept();
  endtask

  task automatic stream(input int npix, input int pct_v, input int pct_r, input int max_cyc);
    int done = 0;
    int cyc = 0;
    bit a;
    while (done < npix && cyc < max_cyc) begin
      cycle($urandom_range(0, 99) < pct_v, $urandom_range(0, 99) < pct_r, a);
      if (a) done++;
      cyc++;
    end
    if (done < npix) begin
      n_chk++;
      n_fail++;
      $display("FAIL stream_timeout: accepted %0d required %0d", done, npix);
    end
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, a);
  endtask

  task automatic check_frame(input string tag, input int base);
    win_t f, l;
    f = gi(base);
    l = gi(base + 35);
    chk({tag, "_count"}, 72'(got.size() - base), 72'd36);
    chk({tag, "_first_bytes"}, f.w, p9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk({tag, "_first_tag"}, {f.row[2:0], f.col[2:0]}, 72'd0);
    chk({tag, "_last_bytes"}, l.w, p9(45, 46, 47, 53, 54, 55, 61, 62, 63));
    chk({tag, "_last_flag"}, 72'(l.last), 72'd1);
  endtask

  // Monitor: every consumed window is popped from the scoreboard and compared.
  initial begin
    win_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && win_valid && win_ready) begin
        e.w = win; e.row = int'(win_row); e.col = int'(win_col); e.last = win_last;
        got.push_back(e);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_window: actual row %0d col %0d required none", win_row, win_col);
        end else begin
          e = exp_q.pop_front();
          chk("win_data", win, e.w);
          chk("win_tag", {win_row, win_col, win_last}, {3'(e.row), 3'(e.col), e.last});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, maxc;
    bit a;
    win_t x;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_pix_ready", 72'(pix_ready), 72'd0);
    chk("rst_win", win, 72'd0);
    chk("rst_tags", {win_row, win_col, win_last}, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_pix_ready", 72'(pix_ready), 72'd1);

    // Full frame, plus the row boundary check
    base = got.size();
    stream(64, 100, 100, 200);
    drain();
    check_frame("full", base);
    x = gi(base + 6);
    chk("row_boundary_tag", {x.row[2:0], x.col[2:0]}, {3'd1, 3'd0});
    maxc = 0;
    for (int i = base; i < got.size(); i++) if (got[i].col > maxc) maxc = got[i].col;
    chk("max_col", 72'(maxc), 72'd5);

    // Backpressure after the first window
    base = got.size();
    stream(19, 100, 100, 100);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, a);
      chk("bp_pix_ready", 72'(pix_ready), 72'd0);
      chk("bp_win_valid", 72'(win_valid), 72'd1);
      chk("bp_win_stable", win, p9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    end
    stream(45, 100, 100, 200);
    drain();
    x = gi(base + 1);
    chk("bp_count", 72'(got.size() - base), 72'd36);
    chk("bp_second_bytes", x.w, p9(1, 2, 3, 9, 10, 11, 17, 18, 19));
    chk("bp_second_tag", {x.row[2:0], x.col[2:0]}, {3'd0, 3'd1});

    // Back-to-back frames
    base = got.size();
    stream(64, 100, 100, 200);
    stream(18, 100, 100, 100);
    cycle(1'b1, 1'b1, a);
    chk("f2_valid_before_19th", 72'(last_vld), 72'd0);
    cycle(1'b1, 1'b1, a);
    chk("f2_valid_after_19th", 72'(last_vld), 72'd1);
    stream(44, 100, 100, 200);
    drain();
    x = gi(base + 36);
    chk("b2b_count", 72'(got.size() - base), 72'd72);
    chk("b2b_f2_first_bytes", x.w, p9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk("b2b_f2_first_tag", {x.row[2:0], x.col[2:0]}, 72'd0);

    // Reset mid-frame drops the pending window and restarts at (0,0)
    stream(30, 100, 100, 100);
    @(negedge clk);
    rst = 1'b1;
    pix_valid = 1'b0;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(posedge clk);
    #1;
    chk("midrst_win_valid", 72'(win_valid), 72'd0);
    chk("midrst_pix_ready", 72'(pix_ready), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    base = got.size();
    stream(64, 100, 100, 200);
    drain();
    check_frame("after_rst", base);

    // Random valid/ready over three frames
    base = got.size();
    stream(192, 50, 50, 20000);
    drain();
    chk("rand_count", 72'(got.size() - base), 72'd108);
    chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
